// File: rtl/float_acc_seq_if.sv
// Handshake and configuration bundle for float_acc_seq: job setup, term stream
// and result stream. The master side drives jobs, the slave side is the accumulator.
interface float_acc_seq_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic [31:0]      cfg_bias;
  logic             cfg_relu;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  modport master (
    output start, cfg_len, cfg_bias, cfg_relu, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  start, cfg_len, cfg_bias, cfg_relu, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/float_acc_seq.sv
// Sequential FP32 accumulator: bias plus cfg_len streamed terms through one
// combinational round-to-nearest-even adder, with optional ReLU on the result.
module FloatAdd (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic        w_swap;
  logic [31:0] w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_d;
  logic [23:0] w_mb, w_ms;
  logic [26:0] w_sh, w_mask, w_shs;
  logic        w_stk, w_inc;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_lim, w_shift, w_e, w_ef;
  logic [26:0] w_n;
  logic [24:0] w_rm;
  logic [22:0] w_fr;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  // NOTE: every variable gets a value on every path of the block, so no latch is inferred.
  always_comb begin
    w_swap = (i_b[30:0] > i_a[30:0]);
    w_big  = w_swap ? i_b : i_a;
    w_sml  = w_swap ? i_a : i_b;
    w_eb   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es   = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_mb   = {|w_big[30:23], w_big[22:0]};
    w_ms   = {|w_sml[30:23], w_sml[22:0]};
    w_d    = w_eb - w_es;

    // Align the smaller operand; bits shifted out collapse into a sticky lsb.
    w_mask = ~(27'h7FF_FFFF << w_d);
    if (w_d >= 8'd27) begin
      w_sh  = '0;
      w_stk = |w_ms;
    end else begin
      w_sh  = {w_ms, 3'b000} >> w_d;
      w_stk = |({w_ms, 3'b000} & w_mask);
    end
    w_shs = {w_sh[26:1], w_sh[0] | w_stk};

    if (w_big[31] == w_sml[31]) w_sum = {1'b0, w_mb, 3'b000} + {1'b0, w_shs};
    else                        w_sum = {1'b0, w_mb, 3'b000} - {1'b0, w_shs};

    w_lz = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end

    // Left normalisation stops at exponent 1 so tiny results stay subnormal.
    w_lim   = {2'b00, w_eb} - 10'd1;
    w_shift = ({5'b0, w_lz} > w_lim) ? w_lim : {5'b0, w_lz};
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = {2'b00, w_eb} + 10'd1;
    end else begin
      w_n = w_sum[26:0] << w_shift;
      w_e = {2'b00, w_eb} - w_shift;
    end

    w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_rm  = {1'b0, w_n[26:3]} + {24'd0, w_inc};
    if (w_rm[24]) begin
      w_ef = w_e + 10'd1;
      w_fr = w_rm[23:1];
    end else begin
      w_ef = w_rm[23] ? w_e : 10'd0;
      w_fr = w_rm[22:0];
    end

    w_a_inf = (&i_a[30:23]) && (i_a[22:0] == 23'd0);
    w_b_inf = (&i_b[30:23]) && (i_b[22:0] == 23'd0);
    w_a_nan = (&i_a[30:23]) && (i_a[22:0] != 23'd0);
    w_b_nan = (&i_b[30:23]) && (i_b[22:0] != 23'd0);

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[31] != i_b[31])))
      o_y = 32'h7FC0_0000;
    else if (w_a_inf)
      o_y = i_a;
    else if (w_b_inf)
      o_y = i_b;
    else if (w_sum == 28'd0)
      o_y = {i_a[31] & i_b[31], 31'd0};
    else if (w_ef >= 10'd255)
      o_y = {w_big[31], 8'hFF, 23'd0};
    else
      o_y = {w_big[31], w_ef[7:0], w_fr};
  end
endmodule

module float_acc_seq #(
  parameter int LEN_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  float_acc_seq_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_relu;
  logic [31:0]      w_sum;

  FloatAdd u_add (
    .i_a (r_acc),
    .i_b (bus.in_data),
    .o_y (w_sum)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= bus.cfg_bias;
            r_cnt   <= bus.cfg_len;
            r_relu  <= bus.cfg_relu;
            r_state <= (bus.cfg_len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (bus.in_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == LEN_W'(1)) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_DONE);
  // Output is forced to zero outside DONE so idle and reset show a clean bus.
  assign bus.out_data  = (r_state != S_DONE)   ? 32'd0 :
                         (r_relu && r_acc[31]) ? 32'd0 : r_acc;
endmodule

// File: tb/tb_float_acc_seq.sv
// Directed bench for float_acc_seq: table of complete jobs plus hand-written
// sequences for stalls, back-pressure, ignored starts and mid-job reset.
module tb_float_acc_seq;
  typedef struct packed {
    logic [31:0]      bias;
    logic [15:0]      len;
    logic             relu;
    logic [0:3][31:0] t;
    logic [31:0]      expv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  float_acc_seq_if #(.LEN_W(16)) bus ();

  float_acc_seq #(.LEN_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] bias, input int len, input bit relu,
                              input logic [31:0] t0, t1, t2, t3, input logic [31:0] expv);
    vec_t v;
    v.bias = bias;
    v.len  = 16'(len);
    v.relu = relu;
    v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
    v.expv = expv;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    bus.start    = 1'b1;
    bus.cfg_bias = v.bias;
    bus.cfg_len  = v.len;
    bus.cfg_relu = v.relu;
    step();
    bus.start = 1'b0;
    check($sformatf("vec%0d.busy_after_start", idx), 32'(bus.busy), 32'd1);
    check($sformatf("vec%0d.in_ready_after_start", idx), 32'(bus.in_ready), 32'(v.len != 0));
    for (int i = 0; i < int'(v.len); i++) begin
      check($sformatf("vec%0d.out_valid_early%0d", idx, i), 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = v.t[i];
      step();
    end
    bus.in_valid = 1'b0;
    check($sformatf("vec%0d.out_valid", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("vec%0d.out_data", idx), bus.out_data, v.expv);
    check($sformatf("vec%0d.in_ready_done", idx), 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check($sformatf("vec%0d.busy_after_hs", idx), 32'(bus.busy), 32'd0);
    check($sformatf("vec%0d.out_valid_after_hs", idx), 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs [7];
    int   accepts;
    bit [5:0] pat;

    vecs[0] = mk(32'h0000_0000, 3, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h0, 32'h4060_0000);
    vecs[1] = mk(32'h4040_0000, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4040_0000);
    vecs[2] = mk(32'h0000_0000, 1, 1'b1, 32'hBF80_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0000);
    vecs[3] = mk(32'h0000_0000, 1, 1'b0, 32'hBF80_0000, 32'h0, 32'h0, 32'h0, 32'hBF80_0000);
    vecs[4] = mk(32'h4040_0000, 1, 1'b0, 32'hC040_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0000);
    vecs[5] = mk(32'h40A0_0000, 1, 1'b1, 32'hBF80_0000, 32'h0, 32'h0, 32'h0, 32'h4080_0000);
    vecs[6] = mk(32'h3F80_0000, 1, 1'b0, 32'h3380_0000, 32'h0, 32'h0, 32'h0, 32'h3F80_0000);

    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_bias = '0; bus.cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_data", bus.out_data, 32'd0);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Stalled stream 1,0,0,1,0,1 then back-pressure on the result.
    pat = 6'b101001;
    accepts = 0;
    bus.start = 1'b1; bus.cfg_bias = 32'h3F80_0000; bus.cfg_len = 16'd3; bus.cfg_relu = 1'b0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("gap.in_ready%0d", i), 32'(bus.in_ready), 32'd1);
      bus.in_valid = pat[i];
      bus.in_data  = 32'h3F80_0000;
      if (bus.in_valid && bus.in_ready) accepts++;
      step();
    end
    check("gap.out_valid_latency", 32'(bus.out_valid), 32'd1);
    check("gap.in_ready_after_last", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    if (bus.in_valid && bus.in_ready) accepts++;
    step();
    bus.in_valid = 1'b0;
    check("gap.accepts", 32'(accepts), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gap.hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("gap.hold_data%0d", i), bus.out_data, 32'h4080_0000);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("gap.busy_after_hs", 32'(bus.busy), 32'd0);

    // Starts during ACC, DONE and the DONE handshake are all ignored.
    bus.start = 1'b1; bus.cfg_bias = 32'h0; bus.cfg_len = 16'd2; bus.cfg_relu = 1'b0;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h3F80_0000;
    bus.start = 1'b1; bus.cfg_bias = 32'hC000_0000; bus.cfg_len = 16'd0; bus.cfg_relu = 1'b1;
    step();
    bus.start = 1'b0;
    check("ign.in_ready_acc", 32'(bus.in_ready), 32'd1);
    bus.in_data = 32'h4000_0000;
    step();
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("ign.out_valid_done", 32'(bus.out_valid), 32'd1);
    check("ign.out_data_done", bus.out_data, 32'h4040_0000);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    check("ign.busy_after_hs", 32'(bus.busy), 32'd0);
    check("ign.out_valid_after_hs", 32'(bus.out_valid), 32'd0);

    // Reset after 2 of 4 terms, then an immediate new job.
    bus.start = 1'b1; bus.cfg_bias = 32'h0; bus.cfg_len = 16'd4; bus.cfg_relu = 1'b0;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h3F80_0000;
    step();
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.out_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    run_vec(100, mk(32'h4000_0000, 1, 1'b0, 32'h4040_0000, 32'h0, 32'h0, 32'h0, 32'h40A0_0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
